boid_sweep_ctrl: RTL and testbench
==================================

BOID_SWEEP_CTRL -- requirements
Module: boid_sweep_ctrl

Interface
REQ-001 SHALL have parameter N_BOIDS, default 32, meaning number of boids per frame (range 2..64).
REQ-002 SHALL have parameter AW, default 6, meaning boid memory address width (2^AW >= N_BOIDS).
REQ-003 SHALL have parameter WB_CYCLES, default 2, meaning writeback settle cycles per boid (range 1..7).
REQ-004 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: start  input  1  frame request, sampled in IDLE only.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse at frame end.
REQ-009 SHALL have port: rd_en  output  1  memory read strobe; data valid one cycle later.
REQ-010 SHALL have port: rd_addr  output  AW  boid read index.
REQ-011 SHALL have port: wr_en  output  1  memory write strobe for datapath outputs.
REQ-012 SHALL have port: wr_addr  output  AW  boid write index.
REQ-013 SHALL have port: bank_sel  output  1  read bank; writes go to ~bank_sel.
REQ-014 SHALL have port: acc_clr  output  1  clears datapath accumulators and neighbour counter.
REQ-015 SHALL have port: r_en_tot  output  1  latch own-boid x/y/vx/vy.
REQ-016 SHALL have port: r_en_itr  output  1  accumulate current neighbour.
REQ-017 SHALL have port: wb_en  output  7  bit0 gates writeback pipeline; bits 6:1 driven 0.

Function
REQ-018 SHALL implement FSM states IDLE, SELF_RD, SELF_LAT, SCAN, DRAIN, WB, DONE.
REQ-019 IDLE: start=1 -> SELF_RD with self index i=0; start while busy SHALL be ignored.
REQ-020 SELF_RD: rd_en=1, rd_addr=i, acc_clr=1; next SELF_LAT.
REQ-021 SELF_LAT: r_en_tot=1 (own data valid); neighbour index j cleared to 0; next SCAN.
REQ-022 SCAN: rd_en=1, rd_addr=j each cycle, j increments; after j=N_BOIDS-1 next DRAIN.
REQ-023 r_en_itr SHALL be a one-cycle-delayed copy of (state==SCAN && j!=i), so self is never accumulated and exactly N_BOIDS-1 pulses occur per boid.
REQ-024 DRAIN: emits final delayed r_en_itr only; next WB with wb counter=0.
REQ-025 WB: wb_en[0]=1 for WB_CYCLES consecutive cycles; wr_en=1, wr_addr=i only on last WB cycle.
REQ-026 After WB: i==N_BOIDS-1 -> DONE, else i+1 -> SELF_RD.
REQ-027 DONE: done=1, bank_sel toggles at exit, next IDLE.
REQ-028 Per-boid latency SHALL be N_BOIDS+3+WB_CYCLES cycles; frame latency from start sample to done = N_BOIDS*(N_BOIDS+3+WB_CYCLES)+1 cycles.
REQ-029 rd_en, wr_en, acc_clr, r_en_tot, r_en_itr, wb_en SHALL be 0 in every state not listed as asserting them.
REQ-030 rd_addr/wr_addr SHALL hold last value when strobes are low; i, j SHALL never exceed N_BOIDS-1.
REQ-031 rd_en and wr_en SHALL never be high in the same cycle.

Reset
REQ-032 reset low SHALL immediately force IDLE, i=j=0, bank_sel=0, all outputs 0, pending r_en_itr cleared.
REQ-033 reset asserted mid-frame SHALL abort without wr_en; bank_sel SHALL not toggle; next start restarts at i=0.
REQ-034 reset release SHALL take effect on first rising clk edge after deassertion.

Verification
REQ-035 N_BOIDS=4, WB_CYCLES=2, start pulse -> done after 4*9+1=37 cycles; wr_en pulses at wr_addr 0,1,2,3; bank_sel 0->1.
REQ-036 Same config, boid i=2 -> r_en_itr pulses aligned with read data of j=0,1,3 only (3 pulses); acc_clr exactly once before them.
REQ-037 start held high continuously -> back-to-back frames, one IDLE cycle between, bank_sel alternates 1,0,1.
REQ-038 reset low during SCAN of i=1 -> all outputs 0 same cycle; no further wr_en; bank_sel stays 0; restart completes normally.
REQ-039 start pulsed while busy -> no effect on counters; exactly one done per accepted frame.
REQ-040 Assertion check over random runs: rd_en&wr_en never both 1; r_en_tot count = wr_en count = N_BOIDS per frame.

Source files
------------

// File: rtl/boid_sweep_ctrl.sv
// Frame sequencer for the boid datapath: per self boid i, read self, scan all j, drain, write back.
// Writes land in the bank opposite bank_sel; bank_sel flips once per completed frame.
module boid_sweep_ctrl #(
  parameter int N_BOIDS   = 32,
  parameter int AW        = 6,
  parameter int WB_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          bank_sel,
  output logic          acc_clr,
  output logic          r_en_tot,
  output logic          r_en_itr,
  output logic [6:0]    wb_en
);

  typedef enum logic [2:0] {
    IDLE, SELF_RD, SELF_LAT, SCAN, DRAIN, WB, DONE
  } state_t;

  localparam logic [AW-1:0] LAST    = AW'(N_BOIDS - 1);
  localparam logic [2:0]    WB_LAST = 3'(WB_CYCLES - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] i_q, j_q, rd_addr_q, wr_addr_q, rd_cur;
  logic [2:0]    wb_q;
  logic          itr_q, bank_q, wb_go, wb_last;

  assign wb_last  = (wb_q == WB_LAST);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign bank_sel = bank_q;
  assign r_en_itr = itr_q;
  assign wb_en    = {6'b0, wb_go};
  // Addresses are only meaningful under their strobe; otherwise they hold the last issued value.
  assign rd_addr  = rd_en ? rd_cur : rd_addr_q;
  assign wr_addr  = wr_en ? i_q : wr_addr_q;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    acc_clr   = 1'b0;
    r_en_tot  = 1'b0;
    wb_go     = 1'b0;
    rd_cur    = i_q;
    case (state)
      IDLE:     if (start) state_nxt = SELF_RD;
      SELF_RD: begin
        rd_en     = 1'b1;
        acc_clr   = 1'b1;
        state_nxt = SELF_LAT;
      end
      SELF_LAT: begin
        r_en_tot  = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        rd_en  = 1'b1;
        rd_cur = j_q;
        if (j_q == LAST) state_nxt = DRAIN;
      end
      DRAIN:    state_nxt = WB;
      WB: begin
        wb_go = 1'b1;
        if (wb_last) begin
          wr_en     = 1'b1;
          state_nxt = (i_q == LAST) ? DONE : SELF_RD;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      wb_q      <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      itr_q     <= 1'b0;
      bank_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr_q <= rd_addr;
      wr_addr_q <= wr_addr;
      // Delayed by one so the pulse lines up with the read data of neighbour j; self is skipped.
      itr_q     <= (state == SCAN) && (j_q != i_q);
      case (state)
        IDLE:     if (start) i_q <= '0;
        SELF_LAT: j_q <= '0;
        SCAN:     j_q <= (j_q == LAST) ? '0 : j_q + 1'b1;
        DRAIN:    wb_q <= '0;
        WB: begin
          if (!wb_last)          wb_q <= wb_q + 3'd1;
          else if (i_q != LAST)  i_q  <= i_q + 1'b1;
        end
        DONE:     bank_q <= ~bank_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_sweep_ctrl.sv
// Directed bench for boid_sweep_ctrl with N_BOIDS=4, WB_CYCLES=2 (9 cycles per boid, done at cycle 37).
module tb_boid_sweep_ctrl;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int WB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en, bank_sel, acc_clr, r_en_tot, r_en_itr;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [6:0]    wb_en;

  int n_cmp = 0;
  int n_err = 0;

  int cyc_done, n_tot, n_itr, n_clr2, n_both, n_rd, n_wb, n_wbhi, n_misal;
  logic [AW-1:0] wr_log[$];
  logic [AW-1:0] itr2[$];

  boid_sweep_ctrl #(.N_BOIDS(N), .AW(AW), .WB_CYCLES(WB)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .bank_sel(bank_sel), .acc_clr(acc_clr), .r_en_tot(r_en_tot),
    .r_en_itr(r_en_itr), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples every cycle of a frame already in progress (current cycle is cycle 1) until done.
  task automatic collect(input bit poke);
    bit seen;
    int cyc;
    logic pv_rd;
    logic [AW-1:0] pv_addr;
    n_tot = 0; n_itr = 0; n_clr2 = 0; n_both = 0; n_rd = 0; n_wb = 0; n_wbhi = 0; n_misal = 0;
    wr_log.delete();
    itr2.delete();
    seen = 0; cyc = 1; pv_rd = 0; pv_addr = '0; cyc_done = -1;
    while (!seen && cyc <= 400) begin
      if (rd_en && wr_en) n_both++;
      if (rd_en) n_rd++;
      if (wr_en) wr_log.push_back(wr_addr);
      if (wb_en[0]) n_wb++;
      if (wb_en[6:1] != 6'd0) n_wbhi++;
      if (acc_clr && n_tot == 2) n_clr2++;
      if (r_en_itr) begin
        n_itr++;
        if (!pv_rd) n_misal++;
        if (n_tot == 3) itr2.push_back(pv_addr);
      end
      if (r_en_tot) n_tot++;
      if (done) begin
        seen = 1;
        cyc_done = cyc;
      end else begin
        pv_rd = rd_en;
        pv_addr = rd_addr;
        if (poke) start = (cyc % 5 == 2);
        step();
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_frame(input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    collect(poke);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({done, rd_en, wr_en, acc_clr, r_en_tot, r_en_itr} !== 6'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 000000", {done, rd_en, wr_en, acc_clr, r_en_tot, r_en_itr}); end
    n_cmp++; if ({rd_addr, wr_addr, wb_en, bank_sel} !== 14'd0) begin n_err++; $display("FAIL reset_addr_wb_bank: got %h want 0", {rd_addr, wr_addr, wb_en, bank_sel}); end
    reset = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_idle: busy %b want 0", busy); end
  endtask

  task automatic test_frame();
    logic [AW-1:0] exp_j[3];
    exp_j = '{3'd0, 3'd1, 3'd3};
    n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL frame_bank_before: got %b want 0", bank_sel); end
    run_frame(1'b0);
    n_cmp++; if (cyc_done !== 37) begin n_err++; $display("FAIL frame_latency: got %0d want 37", cyc_done); end
    n_cmp++; if (wr_log.size() !== 4) begin n_err++; $display("FAIL frame_wr_count: got %0d want 4", wr_log.size()); end
    if (wr_log.size() == 4)
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (wr_log[k] !== AW'(k)) begin n_err++; $display("FAIL frame_wr_addr[%0d]: got %0d want %0d", k, wr_log[k], k); end
      end
    n_cmp++; if (n_tot !== 4) begin n_err++; $display("FAIL frame_tot_count: got %0d want 4", n_tot); end
    n_cmp++; if (n_itr !== 12) begin n_err++; $display("FAIL frame_itr_count: got %0d want 12", n_itr); end
    n_cmp++; if (n_rd !== 20) begin n_err++; $display("FAIL frame_rd_count: got %0d want 20", n_rd); end
    n_cmp++; if (n_wb !== 8) begin n_err++; $display("FAIL frame_wb_cycles: got %0d want 8", n_wb); end
    n_cmp++; if (n_wbhi !== 0) begin n_err++; $display("FAIL frame_wb_upper: got %0d cycles want 0", n_wbhi); end
    n_cmp++; if (n_both !== 0) begin n_err++; $display("FAIL frame_rd_wr_overlap: got %0d want 0", n_both); end
    n_cmp++; if (n_misal !== 0) begin n_err++; $display("FAIL frame_itr_align: got %0d stray pulses want 0", n_misal); end
    n_cmp++; if (n_clr2 !== 1) begin n_err++; $display("FAIL boid2_acc_clr: got %0d want 1", n_clr2); end
    n_cmp++; if (itr2.size() !== 3) begin n_err++; $display("FAIL boid2_itr_count: got %0d want 3", itr2.size()); end
    if (itr2.size() == 3)
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (itr2[k] !== exp_j[k]) begin n_err++; $display("FAIL boid2_itr_j[%0d]: got %0d want %0d", k, itr2[k], exp_j[k]); end
      end
    n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL frame_bank_in_done: got %b want 0", bank_sel); end
    step();
    n_cmp++; if ({busy, done, bank_sel} !== 3'b001) begin n_err++; $display("FAIL frame_after_done: busy/done/bank got %b want 001", {busy, done, bank_sel}); end
  endtask

  task automatic test_start_while_busy();
    int extra;
    run_frame(1'b1);
    n_cmp++; if (cyc_done !== 37) begin n_err++; $display("FAIL busy_start_latency: got %0d want 37", cyc_done); end
    n_cmp++; if (wr_log.size() !== 4) begin n_err++; $display("FAIL busy_start_wr_count: got %0d want 4", wr_log.size()); end
    if (wr_log.size() == 4)
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (wr_log[k] !== AW'(k)) begin n_err++; $display("FAIL busy_start_wr_addr[%0d]: got %0d want %0d", k, wr_log[k], k); end
      end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done || busy) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL busy_start_spurious: got %0d busy/done cycles want 0", extra); end
    n_cmp++; if (bank_sel !== 1'b0) begin n_err++; $display("FAIL busy_start_bank: got %b want 0", bank_sel); end
  endtask

  task automatic test_reset_mid_frame();
    int wr_seen;
    wr_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 13; c++) begin
      if (wr_en) wr_seen++;
      step();
    end
    n_cmp++; if ({rd_en, rd_addr, r_en_itr} !== {1'b1, 3'd1, 1'b1}) begin n_err++; $display("FAIL midrst_in_scan: rd_en/rd_addr/itr got %b want 1_001_1", {rd_en, rd_addr, r_en_itr}); end
    n_cmp++; if (wr_seen !== 1) begin n_err++; $display("FAIL midrst_wr_before: got %0d want 1", wr_seen); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({busy, done, rd_en, wr_en, acc_clr, r_en_tot, r_en_itr, bank_sel} !== 8'b0) begin n_err++; $display("FAIL midrst_outputs: got %b want 00000000", {busy, done, rd_en, wr_en, acc_clr, r_en_tot, r_en_itr, bank_sel}); end
    n_cmp++; if ({rd_addr, wr_addr, wb_en} !== 13'd0) begin n_err++; $display("FAIL midrst_addr_wb: got %h want 0", {rd_addr, wr_addr, wb_en}); end
    wr_seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (wr_en || busy) wr_seen++;
    end
    reset = 1'b1;
    step();
    n_cmp++; if (wr_seen !== 0) begin n_err++; $display("FAIL midrst_activity_in_reset: got %0d want 0", wr_seen); end
    n_cmp++; if ({busy, bank_sel} !== 2'b00) begin n_err++; $display("FAIL midrst_after_release: busy/bank got %b want 00", {busy, bank_sel}); end
    run_frame(1'b0);
    n_cmp++; if (cyc_done !== 37) begin n_err++; $display("FAIL midrst_restart_latency: got %0d want 37", cyc_done); end
    n_cmp++; if (wr_log.size() !== 4) begin n_err++; $display("FAIL midrst_restart_wr_count: got %0d want 4", wr_log.size()); end
    if (wr_log.size() == 4) begin
      n_cmp++; if (wr_log[0] !== 3'd0) begin n_err++; $display("FAIL midrst_restart_first_wr: got %0d want 0", wr_log[0]); end
    end
    step();
    n_cmp++; if (bank_sel !== 1'b1) begin n_err++; $display("FAIL midrst_restart_bank: got %b want 1", bank_sel); end
  endtask

  task automatic test_back_to_back();
    logic exp_bank[3];
    exp_bank = '{1'b1, 1'b0, 1'b1};
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      collect(1'b0);
      start = 1'b1;
      n_cmp++; if (cyc_done !== 37) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want 37", f, cyc_done); end
      step();
      n_cmp++; if ({busy, bank_sel} !== {1'b0, exp_bank[f]}) begin n_err++; $display("FAIL b2b_gap[%0d]: busy/bank got %b want 0%b", f, {busy, bank_sel}, exp_bank[f]); end
      if (f == 2) start = 1'b0;
      step();
      if (f < 2) begin
        n_cmp++; if ({busy, rd_en, rd_addr} !== {2'b11, 3'd0}) begin n_err++; $display("FAIL b2b_restart[%0d]: busy/rd_en/rd_addr got %b want 11000", f, {busy, rd_en, rd_addr}); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop: busy got %b want 0", busy); end
  endtask

  task automatic test_random_frames();
    int gap;
    bit poke;
    for (int f = 0; f < 3; f++) begin
      gap = $urandom_range(0, 4);
      poke = 1'($urandom_range(0, 1));
      repeat (gap) step();
      run_frame(poke);
      n_cmp++; if (n_tot !== 4 || wr_log.size() !== 4) begin n_err++; $display("FAIL rand_tot_wr[%0d]: tot %0d wr %0d want 4/4", f, n_tot, wr_log.size()); end
      n_cmp++; if (n_both !== 0) begin n_err++; $display("FAIL rand_rd_wr_overlap[%0d]: got %0d want 0", f, n_both); end
      n_cmp++; if (cyc_done !== 37) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 37", f, cyc_done); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
